// File: rtl/array_frame_feeder.sv
// Byte FIFO that emits FRAME_LEN-byte frames (zero-padded on flush); first beat registered one edge after a frame's worth is queued; downstream cannot stall, producer is throttled by in_ready.
// Define FEEDER_CHECKSUM_EN to add out_csum, the mod-256 sum of the frame presented on the eof beat.
module array_frame_feeder #(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
`ifdef FEEDER_CHECKSUM_EN
    ,
    output logic [7:0]             out_csum
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam logic [LW-1:0] FL_LVL    = LW'(FRAME_LEN);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] FL_CNT    = CW'(FRAME_LEN);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_PAD} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level, r_n, w_start_n;
    logic [CW-1:0] r_cnt;
    logic          r_out_valid, r_out_sof, r_out_eof, r_ovf;
    logic [7:0]    r_out_data, w_beat_data;
    logic          w_in_ready, w_push, w_pop, w_beat, w_start, w_zero, w_last;

    assign w_in_ready  = (r_level != DEPTH_LVL);
    assign w_push      = in_valid && w_in_ready;
    assign w_beat_data = w_zero ? 8'h00 : r_mem[r_rptr];
    // The opening beat can never be the last one because FRAME_LEN >= 2.
    assign w_last      = w_beat && !w_start && (r_cnt == FL_CNT - CW'(1));

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_beat    = 1'b0;
        w_start   = 1'b0;
        w_zero    = 1'b0;
        w_start_n = FL_LVL;
        case (r_state)
            S_IDLE: begin
                if (r_level >= FL_LVL) begin
                    w_start = 1'b1;
                end else if (flush && r_level != '0) begin
                    w_start   = 1'b1;
                    w_start_n = r_level;
                end
                if (w_start) begin
                    w_pop  = 1'b1;
                    w_beat = 1'b1;
                    w_next = S_BURST;
                end
            end
            S_BURST: begin
                // r_n freezes the frame's byte count so later pushes wait for the next frame.
                if (r_cnt == FL_CNT) begin
                    w_next = S_IDLE;
                end else if (LW'(r_cnt) < r_n) begin
                    w_pop  = 1'b1;
                    w_beat = 1'b1;
                end else begin
                    w_beat = 1'b1;
                    w_zero = 1'b1;
                    w_next = S_PAD;
                end
            end
            S_PAD: begin
                if (r_cnt == FL_CNT) begin
                    w_next = S_IDLE;
                end else begin
                    w_beat = 1'b1;
                    w_zero = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_data  <= 8'h00;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_start) begin
                r_n   <= w_start_n;
                r_cnt <= CW'(1);
            end else if (w_beat) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_out_valid <= w_beat;
            r_out_sof   <= w_start;
            r_out_eof   <= w_last;
            if (w_beat) begin
                r_out_data <= w_beat_data;
            end
            if (in_valid && !w_in_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef FEEDER_CHECKSUM_EN
    logic [7:0] r_csum_acc, r_out_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum_acc <= 8'h00;
            r_out_csum <= 8'h00;
        end else begin
            if (w_start) begin
                r_csum_acc <= w_beat_data;
            end else if (w_beat) begin
                r_csum_acc <= r_csum_acc + w_beat_data;
            end
            r_out_csum <= w_last ? (r_csum_acc + w_beat_data) : 8'h00;
        end
    end

    assign out_csum = r_out_csum;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign ovf       = r_ovf;
    assign level     = r_level;

endmodule

// File: doc/array_frame_feeder.md
ARRAY_FRAME_FEEDER -- requirements
Module: array_frame_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, at least 2*FRAME_LEN.
REQ-002 Parameter FRAME_LEN, default 8, bytes per emitted frame; power of two, 2..DEPTH/2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer byte valid.
REQ-006 in_data  input  8  producer byte.
REQ-007 in_ready  output  1  FIFO can accept a byte (combinational, = !full).
REQ-008 flush  input  1  single-cycle request to emit a partial frame, zero-padded.
REQ-009 out_valid  output  1  registered; byte valid to the downstream array processor, which has no backpressure.
REQ-010 out_data  output  8  registered frame byte.
REQ-011 out_sof / out_eof  output  1 each  registered; first / last beat of a frame.
REQ-012 ovf  output  1  sticky flag: a push was attempted while in_ready=0.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A push SHALL occur on an edge where in_valid=1 and in_ready=1; bytes SHALL be stored in arrival order.
REQ-015 in_valid=1 with in_ready=0 SHALL drop the byte and set ovf; FIFO contents SHALL be unchanged.
REQ-016 FSM states SHALL be IDLE, BURST and PAD.
REQ-017 IDLE -> BURST at an edge where level>=FRAME_LEN; that same edge SHALL register the first beat (out_valid=1, out_sof=1, FIFO head popped).
- Latency: the 8th byte is accepted at edge E; the first beat is visible after edge E+1.
REQ-018 BURST SHALL emit exactly FRAME_LEN consecutive beats, one pop per cycle, with no gaps.
REQ-019 The final beat SHALL assert out_eof; the next edge SHALL return to IDLE with out_valid=0.
- At least one idle cycle SHALL separate frames.
REQ-020 flush in IDLE with 0<level<FRAME_LEN SHALL latch n=level and enter BURST.
- Emits n FIFO bytes, then PAD emits FRAME_LEN-n beats of 0x00.
- out_eof on the last pad beat.
- sof/eof/valid timing SHALL be identical to a full frame.
REQ-021 flush SHALL be ignored when level==0, when level>=FRAME_LEN (a normal frame is emitted), or when not in IDLE.
REQ-022 Bytes pushed during a flushed frame SHALL NOT join that frame; they SHALL remain queued for the next frame.
REQ-023 A simultaneous push and pop SHALL leave level unchanged.
- A push into a full FIFO in the same cycle as a pop SHALL still be refused, since in_ready depends only on full.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH inclusive.
REQ-025 out_valid=0 SHALL force out_sof=0 and out_eof=0; out_data is don't-care but SHALL hold its last value.

Reset
REQ-026 rst SHALL asynchronously set: state=IDLE, pointers=0, level=0, out_valid=0, out_sof=0, out_eof=0, out_data=0x00, ovf=0.
- Checksum accumulator = 0 when compiled in.
REQ-027 rst asserted mid-frame SHALL abort the frame immediately and discard all FIFO contents; no eof SHALL be emitted.
REQ-028 After rst deasserts, the first edge SHALL already accept pushes.

Configuration
REQ-029 Macro FEEDER_CHECKSUM_EN defined SHALL add output out_csum [7:0].
- out_csum = modulo-256 sum of all FRAME_LEN beats of the frame, pad zeros included.
- Valid, and registered, on the out_eof beat; 0x00 on all other cycles.
- Cross-checks the downstream sum_out.
REQ-030 Macro FEEDER_CHECKSUM_EN undefined SHALL remove the out_csum port and its accumulator; all other behaviour SHALL be identical.

Verification
REQ-031 Push 0x01..0x08 on consecutive cycles -> out_sof with 0x01 one edge after 0x08 accepted; 8 contiguous beats 0x01..0x08; eof on 0x08; csum=0x24.
REQ-032 Push 0xA0,0xA1,0xA2 then pulse flush -> beats A0,A1,A2,00,00,00,00,00; eof on beat 8; csum=0xE3; level=0 afterward.
REQ-033 Hold in_valid=1 with no frame drain until full -> in_ready=0 at level=16; 17th push sets ovf=1; contents intact.
- Subsequent frames SHALL deliver the first 16 bytes in order.
REQ-034 Push 20 bytes back-to-back (0x10..0x23) -> two frames 0x10..0x17 and 0x18..0x1F, separated by ≥1 idle cycle; level=4 remains.
- Simultaneous push/pop SHALL not corrupt the count.
REQ-035 Assert rst on the 4th beat of a frame -> out_valid=0 immediately; level=0, ovf=0.
- Next 8 pushes produce a clean frame from the new data only.
REQ-036 Pulse flush with level=0, and again during BURST -> no extra beats; the FIFO is unaffected.
